// File: rtl/bcd_addsub_serial.sv
// Digit-serial N-digit packed-BCD adder/subtractor with start/ready/done handshake.
// A negative difference is turned back into sign + magnitude by a second serial pass.
module bcd_addsub_serial #(
  parameter  int DIGITS = 4,
  localparam int CNT_W  = $clog2(DIGITS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  sub,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  cin,
  output logic                  ready,
  output logic                  done,
  output logic [4*DIGITS-1:0]   result,
  output logic                  cout,
  output logic                  neg,
  output logic                  invalid
);

  localparam int W = 4 * DIGITS;

  // state  | meaning
  // IDLE   | waiting for start, ready=1
  // ADD    | serial a + b (or a + nines(b) + 1), one digit per cycle
  // FIX    | serial ten's complement of a negative difference
  // DONE   | one-cycle done pulse, outputs valid
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADD  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  function automatic logic [W-1:0] nines(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'd9 - v[4*i +: 4];
    return r;
  endfunction

  function automatic logic has_bad(input logic [W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) if (v[4*i +: 4] > 4'd9) bad = 1'b1;
    return bad;
  endfunction

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     opa_q, opa_d;
  logic [W-1:0]     opb_q, opb_d;
  logic [W-1:0]     res_q, res_d;
  logic             carry_q, carry_d;
  logic             sub_q, sub_d;
  logic             inv_q, inv_d;
  logic [W-1:0]     result_q, result_d;
  logic             cout_q, cout_d;
  logic             neg_q, neg_d;
  logic             invalid_q, invalid_d;

  logic [4:0]       dsum;
  logic [4:0]       dsum6;
  logic             corr;
  logic [3:0]       digit;
  logic [W-1:0]     res_shift;
  logic             last;

  always_comb begin
    dsum      = {1'b0, opa_q[3:0]} + {1'b0, opb_q[3:0]} + {4'b0, carry_q};
    dsum6     = dsum + 5'd6;
    corr      = dsum > 5'd9;
    digit     = corr ? dsum6[3:0] : dsum[3:0];
    res_shift = W'({digit, res_q} >> 4);
    last      = cnt_q == CNT_W'(DIGITS - 1);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    res_d     = res_q;
    carry_d   = carry_q;
    sub_d     = sub_q;
    inv_d     = inv_q;
    result_d  = result_q;
    cout_d    = cout_q;
    neg_d     = neg_q;
    invalid_d = invalid_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          opa_d   = a;
          opb_d   = sub ? nines(b) : b;
          carry_d = sub ? 1'b1 : cin;
          sub_d   = sub;
          inv_d   = has_bad(a) | has_bad(b);
          cnt_d   = '0;
          state_d = S_ADD;
        end
      end
      S_ADD, S_FIX: begin
        opa_d   = opa_q >> 4;
        opb_d   = opb_q >> 4;
        carry_d = corr;
        res_d   = res_shift;
        cnt_d   = cnt_q + CNT_W'(1);
        if (last) begin
          if (inv_q) begin
            result_d  = '0;
            cout_d    = 1'b0;
            neg_d     = 1'b0;
            invalid_d = 1'b1;
            state_d   = S_DONE;
          end else if (state_q == S_ADD && sub_q && !corr) begin
            // Borrow out: complement the just-finished difference in a second pass.
            opa_d   = nines(res_shift);
            opb_d   = '0;
            carry_d = 1'b1;
            cnt_d   = '0;
            state_d = S_FIX;
          end else begin
            result_d  = res_shift;
            cout_d    = (state_q == S_ADD) ? corr : 1'b0;
            neg_d     = (state_q == S_FIX);
            invalid_d = 1'b0;
            state_d   = S_DONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      res_q     <= '0;
      carry_q   <= 1'b0;
      sub_q     <= 1'b0;
      inv_q     <= 1'b0;
      result_q  <= '0;
      cout_q    <= 1'b0;
      neg_q     <= 1'b0;
      invalid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      res_q     <= res_d;
      carry_q   <= carry_d;
      sub_q     <= sub_d;
      inv_q     <= inv_d;
      result_q  <= result_d;
      cout_q    <= cout_d;
      neg_q     <= neg_d;
      invalid_q <= invalid_d;
    end
  end

  assign ready   = state_q == S_IDLE;
  assign done    = state_q == S_DONE;
  assign result  = result_q;
  assign cout    = cout_q;
  assign neg     = neg_q;
  assign invalid = invalid_q;

endmodule

// File: tb/tb_bcd_addsub_serial.sv
// Directed bench for bcd_addsub_serial (DIGITS=4) with hand-computed expectations.
module tb_bcd_addsub_serial;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        sub;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        ready;
  logic        done;
  logic [15:0] result;
  logic        cout;
  logic        neg;
  logic        invalid;

  int n_pass  = 0;
  int n_total = 0;

  bcd_addsub_serial #(.DIGITS(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .sub     (sub),
    .a       (a),
    .b       (b),
    .cin     (cin),
    .ready   (ready),
    .done    (done),
    .result  (result),
    .cout    (cout),
    .neg     (neg),
    .invalid (invalid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input string field,
                       input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s.%s: got %0h expected %0h", tag, field, obs, exp);
  endtask

  // Starts one operation right away (DUT must be idle), optionally pulses start
  // again in busy cycle pulse_at, then checks latency, outputs and pulse width.
  task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                        input logic tsub, input logic tcin, input int pulse_at,
                        input logic [15:0] er, input logic ecout, input logic eneg,
                        input logic einv, input int ecyc);
    int cyc;
    check(tag, "ready_before", 32'(ready), 32'd1);
    a = ta; b = tb_v; sub = tsub; cin = tcin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 40) begin
      if (cyc == pulse_at) begin
        a = 16'h1111; b = 16'h2222; sub = 1'b1; start = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
    end
    check(tag, "done_cycle", 32'(cyc), 32'(ecyc));
    check(tag, "result", 32'(result), 32'(er));
    check(tag, "cout", 32'(cout), 32'(ecout));
    check(tag, "neg", 32'(neg), 32'(eneg));
    check(tag, "invalid", 32'(invalid), 32'(einv));
    @(posedge clk); #1;
    check(tag, "done_width", 32'(done), 32'd0);
    check(tag, "ready_after", 32'(ready), 32'd1);
    check(tag, "result_hold", 32'(result), 32'(er));
  endtask

  initial begin
    int pulses;
    rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset", "ready", 32'(ready), 32'd1);
    check("reset", "done", 32'(done), 32'd0);
    check("reset", "result", 32'(result), 32'd0);
    check("reset", "flags", {29'd0, cout, neg, invalid}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op("add1",  16'h1234, 16'h5678, 1'b0, 1'b0, 0, 16'h6912, 1'b0, 1'b0, 1'b0, 5);
    run_op("add2",  16'h9999, 16'h0001, 1'b0, 1'b0, 0, 16'h0000, 1'b1, 1'b0, 1'b0, 5);
    run_op("add3",  16'h9999, 16'h9999, 1'b0, 1'b1, 0, 16'h9999, 1'b1, 1'b0, 1'b0, 5);
    run_op("add4",  16'h0045, 16'h0037, 1'b0, 1'b1, 0, 16'h0083, 1'b0, 1'b0, 1'b0, 5);
    run_op("sub1",  16'h5000, 16'h1234, 1'b1, 1'b0, 0, 16'h3766, 1'b1, 1'b0, 1'b0, 5);
    run_op("sub2",  16'h0456, 16'h0456, 1'b1, 1'b1, 0, 16'h0000, 1'b1, 1'b0, 1'b0, 5);
    run_op("sub3",  16'h0123, 16'h0456, 1'b1, 1'b0, 0, 16'h0333, 1'b0, 1'b1, 1'b0, 9);
    run_op("sub4",  16'h0000, 16'h0001, 1'b1, 1'b0, 0, 16'h0001, 1'b0, 1'b1, 1'b0, 9);
    run_op("inv1",  16'h12A4, 16'h0001, 1'b0, 1'b0, 0, 16'h0000, 1'b0, 1'b0, 1'b1, 5);
    run_op("clr",   16'h0010, 16'h0020, 1'b0, 1'b0, 0, 16'h0030, 1'b0, 1'b0, 1'b0, 5);
    run_op("inv2",  16'h0001, 16'hF000, 1'b1, 1'b0, 0, 16'h0000, 1'b0, 1'b0, 1'b1, 5);
    run_op("busy",  16'h1234, 16'h5678, 1'b0, 1'b0, 2, 16'h6912, 1'b0, 1'b0, 1'b0, 5);
    run_op("sub5",  16'h0123, 16'h0456, 1'b1, 1'b0, 6, 16'h0333, 1'b0, 1'b1, 1'b0, 9);

    // Reset in the second ADD cycle of a new op while old flags (neg=1) are held.
    a = 16'h4321; b = 16'h1111; sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst", "ready", 32'(ready), 32'd1);
    check("midrst", "done", 32'(done), 32'd0);
    check("midrst", "result", 32'(result), 32'd0);
    check("midrst", "flags", {29'd0, cout, neg, invalid}, 32'd0);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    check("midrst", "no_done", 32'(pulses), 32'd0);
    check("midrst", "ready_idle", 32'(ready), 32'd1);

    run_op("post",  16'h0999, 16'h0001, 1'b0, 1'b0, 0, 16'h1000, 1'b0, 1'b0, 1'b0, 5);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
